// File: rtl/instruction_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instruction_encoder_pkg
// Purpose : Shared definitions for the RV32I instruction encoder. This file
//           holds the format codes, the canonical nop word, the immediate
//           limits, the stage-1 field bundle and the word packing helper.
//           The format codes match the immediate extractor's SELECTION
//           encoding.
// Revision: 1.0 - initial release
// ============================================================================
package instruction_encoder_pkg;

    // Format selector codes. Codes 6 and 7 are invalid.
    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_U  = 3'd2;
    localparam logic [2:0] FMT_S  = 3'd3;
    localparam logic [2:0] FMT_B  = 3'd4;
    localparam logic [2:0] FMT_UJ = 3'd5;

    // Encoding of addi x0,x0,0. It is emitted for invalid formats.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Signed ranges that each immediate field can represent.
    localparam int IMM_IS_MIN = -2048;
    localparam int IMM_IS_MAX = 2047;
    localparam int IMM_B_MIN  = -4096;
    localparam int IMM_B_MAX  = 4094;
    localparam int IMM_UJ_MIN = -1048576;
    localparam int IMM_UJ_MAX = 1048574;

    typedef struct packed {
        logic [2:0]  sel;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    // Scatter the fields into the RV32I layout. An immediate that is out of
    // range is still packed; only its representable low bits are kept.
    function automatic logic [31:0] pack_word(fields_t f);
        logic [31:0] w;
        w = NOP_INSN;
        case (f.sel)
            FMT_R:   w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I:   w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_U:   w = {f.imm[31:12], f.rd, f.opcode};
            FMT_S:   w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            FMT_B:   w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                          f.imm[4:1], f.imm[11], f.opcode};
            FMT_UJ:  w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                          f.rd, f.opcode};
            default: w = NOP_INSN;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_encoder_imm_range_check.sv
`default_nettype none
// ============================================================================
// Module  : imm_range_check
// Purpose : Combinational check that reports whether IMMEDIATE fits the
//           immediate field of the selected format.
// Ports   : i_sel [2:0]  - format code
//           i_imm [31:0] - signed immediate (for U, the full shifted value)
//           o_err        - 1 when the immediate cannot be encoded exactly
// Revision: 1.0 - initial release
// ============================================================================
module imm_range_check
    import instruction_encoder_pkg::*;
(
    input  logic [2:0]  i_sel,
    input  logic [31:0] i_imm,
    output logic        o_err
);

    logic signed [31:0] w_simm;

    always_comb begin
        w_simm = $signed(i_imm);
        o_err  = 1'b0;
        case (i_sel)
            FMT_R:        o_err = 1'b0;
            FMT_I, FMT_S: o_err = (w_simm < IMM_IS_MIN) || (w_simm > IMM_IS_MAX);
            // Branch and jump offsets drop bit 0, so odd values are not encodable.
            FMT_B:        o_err = (w_simm < IMM_B_MIN) || (w_simm > IMM_B_MAX) || i_imm[0];
            FMT_UJ:       o_err = (w_simm < IMM_UJ_MIN) || (w_simm > IMM_UJ_MAX) || i_imm[0];
            // U carries only bits 31:12, so any low bits are lost.
            FMT_U:        o_err = |i_imm[11:0];
            default:      o_err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module  : instruction_encoder
// Purpose : Two-stage valid/ready pipeline. It packs RV32I fields into a
//           32-bit word and tags the word with an instruction-memory byte
//           address and an immediate range flag.
// Ports   : CLK, RST_N (async active-low), CLEAR (sync counter/sticky clear)
//           IN_VALID/IN_READY + SELECTION, OPCODE, RD, RS1, RS2, FUNCT3,
//           FUNCT7, IMMEDIATE   - input field set
//           OUT_VALID/OUT_READY + INSTRUCTION, ADDRESS, RANGE_ERROR - output
//           STICKY_ERROR        - OR of emitted RANGE_ERROR since reset/CLEAR
// Revision: 1.0 - initial release
// ============================================================================
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLEAR,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [2:0]        SELECTION,
    input  logic [6:0]        OPCODE,
    input  logic [4:0]        RD,
    input  logic [4:0]        RS1,
    input  logic [4:0]        RS2,
    input  logic [2:0]        FUNCT3,
    input  logic [6:0]        FUNCT7,
    input  logic [31:0]       IMMEDIATE,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [31:0]       INSTRUCTION,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic              RANGE_ERROR,
    output logic              STICKY_ERROR
);

    fields_t           w_in_fields;
    logic              w_in_err;
    logic              w_s1_ready, w_s2_ready, w_in_xfer, w_out_xfer;

    logic              in_ready_en_q, in_ready_en_d;
    logic              s1_valid_q, s1_valid_d;
    fields_t           s1_fields_q, s1_fields_d;
    logic              s1_err_q, s1_err_d;
    logic              s2_valid_q, s2_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic              range_err_q, range_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sticky_q, sticky_d;

    assign w_in_fields = '{sel: SELECTION, opcode: OPCODE, rd: RD, rs1: RS1,
                           rs2: RS2, funct3: FUNCT3, funct7: FUNCT7, imm: IMMEDIATE};

    // The range check is evaluated on the incoming fields and captured with them.
    imm_range_check u_imm_range_check (
        .i_sel (SELECTION),
        .i_imm (IMMEDIATE),
        .o_err (w_in_err)
    );

    assign w_s2_ready = !s2_valid_q || OUT_READY;
    assign w_s1_ready = !s1_valid_q || w_s2_ready;
    // This flag holds IN_READY low during reset and for the edge at which reset is released.
    assign IN_READY   = in_ready_en_q && w_s1_ready;
    assign w_in_xfer  = IN_VALID && IN_READY;
    assign w_out_xfer = s2_valid_q && OUT_READY;

    always_comb begin
        in_ready_en_d = 1'b1;

        s1_valid_d  = s1_valid_q;
        s1_fields_d = s1_fields_q;
        s1_err_d    = s1_err_q;
        if (w_s1_ready) begin
            s1_valid_d = w_in_xfer;
        end
        if (w_in_xfer) begin
            s1_fields_d = w_in_fields;
            s1_err_d    = w_in_err;
        end

        s2_valid_d  = s2_valid_q;
        instr_d     = instr_q;
        range_err_d = range_err_q;
        if (w_s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d     = pack_word(s1_fields_q);
                range_err_d = s1_err_q;
            end
        end

        // CLEAR has priority. The word leaving in the same cycle keeps the old address.
        addr_d = addr_q;
        if (CLEAR) begin
            addr_d = BASE_ADDR;
        end else if (w_out_xfer) begin
            addr_d = addr_q + ADDR_W'(4);
        end

        sticky_d = sticky_q;
        if (CLEAR) begin
            sticky_d = 1'b0;
        end else if (w_out_xfer && range_err_q) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_ready_en_q <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_fields_q   <= '0;
            s1_err_q      <= 1'b0;
            s2_valid_q    <= 1'b0;
            instr_q       <= '0;
            range_err_q   <= 1'b0;
            addr_q        <= BASE_ADDR;
            sticky_q      <= 1'b0;
        end else begin
            in_ready_en_q <= in_ready_en_d;
            s1_valid_q    <= s1_valid_d;
            s1_fields_q   <= s1_fields_d;
            s1_err_q      <= s1_err_d;
            s2_valid_q    <= s2_valid_d;
            instr_q       <= instr_d;
            range_err_q   <= range_err_d;
            addr_q        <= addr_d;
            sticky_q      <= sticky_d;
        end
    end

    assign OUT_VALID    = s2_valid_q;
    assign INSTRUCTION  = instr_q;
    assign ADDRESS      = addr_q;
    assign RANGE_ERROR  = range_err_q;
    assign STICKY_ERROR = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_encoder
// Purpose : Self-checking bench for instruction_encoder. It drives two
//           instances: the default ADDR_W=12 and a narrow ADDR_W=4 for the
//           address wrap. A behavioural model predicts the outputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instruction_encoder;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CLEAR = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        OUT_READY = 1'b1;
    logic [2:0]  SELECTION = '0;
    logic [6:0]  OPCODE = '0;
    logic [4:0]  RD = '0, RS1 = '0, RS2 = '0;
    logic [2:0]  FUNCT3 = '0;
    logic [6:0]  FUNCT7 = '0;
    logic [31:0] IMMEDIATE = '0;

    logic        in_ready, out_valid, range_err, sticky;
    logic [31:0] instr;
    logic [11:0] address;
    logic        in_ready_w, out_valid_w, range_err_w, sticky_w;
    logic [31:0] instr_w;
    logic [3:0]  address_w;

    always #5 CLK = ~CLK;

    instruction_encoder #(.ADDR_W(12), .BASE_ADDR(12'h000)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .IN_VALID(IN_VALID), .IN_READY(in_ready),
        .SELECTION(SELECTION), .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2),
        .FUNCT3(FUNCT3), .FUNCT7(FUNCT7), .IMMEDIATE(IMMEDIATE), .OUT_VALID(out_valid),
        .OUT_READY(OUT_READY), .INSTRUCTION(instr), .ADDRESS(address),
        .RANGE_ERROR(range_err), .STICKY_ERROR(sticky)
    );

    instruction_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut_w (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .IN_VALID(IN_VALID), .IN_READY(in_ready_w),
        .SELECTION(SELECTION), .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2),
        .FUNCT3(FUNCT3), .FUNCT7(FUNCT7), .IMMEDIATE(IMMEDIATE), .OUT_VALID(out_valid_w),
        .OUT_READY(OUT_READY), .INSTRUCTION(instr_w), .ADDRESS(address_w),
        .RANGE_ERROR(range_err_w), .STICKY_ERROR(sticky_w)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } vec_t;

    typedef struct { logic [31:0] w; logic e; int t; } exp_t;
    typedef struct { logic [31:0] w; logic e; logic [11:0] a; logic [3:0] aw; } obs_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    bit   rel   = 1'b0;
    logic [11:0] m_addr = '0;
    logic [3:0]  m_addr_w = '0;
    logic        m_sticky = 1'b0;
    exp_t exp_q[$];
    obs_t obs[$];
    vec_t pend[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Packing rules written as shift/mask arithmetic on 32-bit quantities.
    function automatic logic [31:0] enc(vec_t v);
        logic [31:0] im, op, rd, rs1, rs2, f3, f7;
        im = v.imm; op = 32'(v.op); rd = 32'(v.rd); rs1 = 32'(v.rs1);
        rs2 = 32'(v.rs2); f3 = 32'(v.f3); f7 = 32'(v.f7);
        case (v.sel)
            3'd0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd1: return ((im & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd2: return (im & 32'hFFFF_F000) | (rd << 7) | op;
            3'd3: return (((im >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                         | ((im & 32'h1F) << 7) | op;
            3'd4: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (rs2 << 20)
                         | (rs1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
                         | (((im >> 11) & 32'h1) << 7) | op;
            3'd5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                         | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                         | (rd << 7) | op;
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic logic bad_imm(vec_t v);
        int s;
        s = $signed(v.imm);
        case (v.sel)
            3'd0:       return 1'b0;
            3'd1, 3'd3: return (s < -2048) || (s > 2047);
            3'd4:       return (s < -4096) || (s > 4094) || (s % 2 != 0);
            3'd5:       return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
            3'd2:       return (v.imm % 32'd4096) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic vec_t mk(int sel, int op, int rd, int rs1, int rs2, int f3, int f7, int imm);
        vec_t v;
        v.sel = 3'(sel); v.op = 7'(op); v.rd = 5'(rd); v.rs1 = 5'(rs1);
        v.rs2 = 5'(rs2); v.f3 = 3'(f3); v.f7 = 7'(f7); v.imm = 32'(imm);
        return v;
    endfunction

    // Model: words in flight form a FIFO, and the front becomes visible two
    // cycles after its acceptance. The pipeline holds at most two words.
    always @(negedge CLK) begin
        logic e_valid, e_ready;
        vec_t cur;
        exp_t e;
        obs_t o;
        if (!RST_N) begin
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_in_ready", in_ready, 1'b0);
            exp_q.delete();
            m_addr = '0; m_addr_w = '0; m_sticky = 1'b0; rel = 1'b0;
        end else begin
            e_valid = (exp_q.size() > 0) && (cyc - exp_q[0].t >= 2);
            e_ready = rel && !(exp_q.size() == 2 && !OUT_READY);
            chk("out_valid", out_valid, e_valid);
            chk("out_valid_w", out_valid_w, e_valid);
            chk("in_ready", in_ready, e_ready);
            chk("in_ready_w", in_ready_w, e_ready);
            chk("sticky", sticky, m_sticky);
            chk("sticky_w", sticky_w, m_sticky);
            if (e_valid) begin
                chk("instruction", instr, exp_q[0].w);
                chk("instruction_w", instr_w, exp_q[0].w);
                chk("range_error", range_err, exp_q[0].e);
                chk("range_error_w", range_err_w, exp_q[0].e);
                chk("address", address, m_addr);
                chk("address_w", address_w, m_addr_w);
            end
            if (out_valid && OUT_READY) begin
                o.w = instr; o.e = range_err; o.a = address; o.aw = address_w;
                obs.push_back(o);
            end
            if (e_valid && OUT_READY) begin
                if (exp_q[0].e) m_sticky = 1'b1;
                exp_q.delete(0);
                m_addr   = m_addr + 12'd4;
                m_addr_w = m_addr_w + 4'd4;
            end
            if (CLEAR) begin
                m_addr = '0; m_addr_w = '0; m_sticky = 1'b0;
            end
            if (e_ready && IN_VALID) begin
                cur.sel = SELECTION; cur.op = OPCODE; cur.rd = RD; cur.rs1 = RS1;
                cur.rs2 = RS2; cur.f3 = FUNCT3; cur.f7 = FUNCT7; cur.imm = IMMEDIATE;
                e.w = enc(cur); e.e = bad_imm(cur); e.t = cyc;
                exp_q.push_back(e);
            end
            rel = 1'b1;
        end
        cyc++;
    end

    task automatic load();
        if (pend.size() > 0) begin
            IN_VALID = 1'b1;
            SELECTION = pend[0].sel; OPCODE = pend[0].op; RD = pend[0].rd;
            RS1 = pend[0].rs1; RS2 = pend[0].rs2; FUNCT3 = pend[0].f3;
            FUNCT7 = pend[0].f7; IMMEDIATE = pend[0].imm;
        end else begin
            IN_VALID = 1'b0;
        end
    endtask

    task automatic tick();
        logic acc;
        @(negedge CLK);
        acc = IN_VALID && in_ready;
        @(posedge CLK);
        #1;
        if (acc) begin
            n_acc++;
            if (pend.size() > 0) pend.delete(0);
        end
        load();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < 200) begin
            tick();
            n++;
        end
        if (pend.size() > 0 || exp_q.size() > 0)
            chk("drain_timeout", 64'(pend.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] basic_words [5];
        logic [31:0] bp_words [4];
        basic_words = '{32'h00A00613, 32'h00001337, 32'h00B323A3, 32'hFEC5CAE3, 32'h4000006F};
        bp_words    = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_instruction", instr, 32'h0);
        chk("reset_address", address, 12'h000);
        chk("reset_range_error", range_err, 1'b0);
        chk("reset_sticky", sticky, 1'b0);
        RST_N = 1'b1;
        tick(); tick();

        // Basic formats, one per cycle
        obs.delete();
        pend.push_back(mk(1, 'h13, 12, 0, 0, 0, 0, 10));
        pend.push_back(mk(2, 'h37, 6, 0, 0, 0, 0, 4096));
        pend.push_back(mk(3, 'h23, 0, 6, 11, 2, 0, 7));
        pend.push_back(mk(4, 'h63, 0, 11, 12, 4, 0, -12));
        pend.push_back(mk(5, 'h6F, 0, 0, 0, 0, 0, 1024));
        load();
        drain();
        chk("basic_count", obs.size(), 5);
        if (obs.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("basic_word", obs[i].w, basic_words[i]);
                chk("basic_addr", obs[i].a, 12'(4 * i));
                chk("basic_err", obs[i].e, 1'b0);
            end
        end

        // Backpressure: OUT_READY low for 3 cycles during a 4-word stream
        obs.delete();
        OUT_READY = 1'b0;
        for (int i = 1; i <= 4; i++) pend.push_back(mk(1, 'h13, i, 0, 0, 0, 0, i));
        load();
        n_acc = 0;
        repeat (3) tick();
        chk("bp_accepted", n_acc, 2);
        chk("bp_in_ready_low", in_ready, 1'b0);
        OUT_READY = 1'b1;
        drain();
        chk("bp_count", obs.size(), 4);
        if (obs.size() == 4)
            for (int i = 0; i < 4; i++) chk("bp_order", obs[i].w, bp_words[i]);

        // Range errors and sticky flag
        obs.delete();
        pend.push_back(mk(1, 'h13, 12, 0, 0, 0, 0, 2048));
        pend.push_back(mk(4, 'h63, 0, 1, 2, 0, 0, -11));
        pend.push_back(mk(2, 'h37, 5, 0, 0, 0, 0, 4097));
        load();
        drain();
        chk("range_count", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("range_i_word", obs[0].w, 32'h80000613);
            chk("range_i_err", obs[0].e, 1'b1);
            chk("range_b_err", obs[1].e, 1'b1);
            chk("range_u_word", obs[2].w, 32'h000012B7);
            chk("range_u_err", obs[2].e, 1'b1);
        end
        chk("sticky_set", sticky, 1'b1);
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        chk("sticky_cleared", sticky, 1'b0);
        chk("clear_address", address, 12'h000);

        // Invalid format
        obs.delete();
        pend.push_back(mk(7, 'h33, 3, 4, 5, 1, 'h20, 99));
        load();
        drain();
        chk("invalid_count", obs.size(), 1);
        if (obs.size() == 1) begin
            chk("invalid_word", obs[0].w, 32'h00000013);
            chk("invalid_err", obs[0].e, 1'b1);
        end

        // Address wrap on the narrow instance
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        obs.delete();
        for (int i = 0; i < 5; i++) pend.push_back(mk(0, 'h33, i, 1, 2, 0, 0, 0));
        load();
        drain();
        chk("wrap_count", obs.size(), 5);
        if (obs.size() == 5) begin
            chk("wrap_a0", obs[0].aw, 4'd0);
            chk("wrap_a3", obs[3].aw, 4'd12);
            chk("wrap_a4", obs[4].aw, 4'd0);
            chk("wide_a4", obs[4].a, 12'd16);
        end

        // CLEAR together with an output transfer
        obs.delete();
        OUT_READY = 1'b0;
        pend.push_back(mk(6, 'h13, 0, 0, 0, 0, 0, 0));
        pend.push_back(mk(1, 'h13, 1, 0, 0, 0, 0, 1));
        load();
        tick(); tick();
        CLEAR = 1'b1;
        OUT_READY = 1'b1;
        tick();
        CLEAR = 1'b0;
        chk("clr_xfer_sticky", sticky, 1'b0);
        drain();
        chk("clr_xfer_count", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("clr_xfer_old_addr", obs[0].a, 12'd20);
            chk("clr_xfer_old_addr_w", obs[0].aw, 4'd4);
            chk("clr_xfer_new_addr", obs[1].a, 12'd0);
            chk("clr_xfer_new_addr_w", obs[1].aw, 4'd0);
        end

        // Reset with two words in flight
        pend.push_back(mk(1, 'h13, 2, 0, 0, 0, 0, 2));
        pend.push_back(mk(1, 'h13, 3, 0, 0, 0, 0, 3));
        load();
        tick(); tick();
        chk("pre_reset_out_valid", out_valid, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid, 1'b0);
        chk("async_reset_address", address, 12'h000);
        pend.delete();
        IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        obs.delete();
        pend.push_back(mk(1, 'h13, 12, 0, 0, 0, 0, 10));
        load();
        drain();
        repeat (3) tick();
        chk("post_reset_count", obs.size(), 1);
        if (obs.size() == 1) begin
            chk("post_reset_word", obs[0].w, 32'h00A00613);
            chk("post_reset_addr", obs[0].a, 12'h000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
